// File: rtl/noc_pkt_pkg.sv
// noc_pkt_pkg: flit field offsets and payload sizing shared by the
// NoC packetizer/depacketizer pair.
package noc_pkt_pkg;

    // Header field offsets, counted down from the flit MSB.
    localparam int HDR_VALID = 0;
    localparam int HDR_HEAD  = 1;
    localparam int HDR_TAIL  = 2;
    localparam int HDR_VC    = 3;

    typedef enum logic {
        EXPECT_HEAD = 1'b0,
        IN_BODY     = 1'b1
    } depkt_state_e;

    // Raw payload width of one flit; only flit 1 of a head word
    // carries the destination field.
    function automatic int payload_w(int fw, int aw, int vcw,
                                     bit head_f1);
        return fw - HDR_VC - vcw - (head_f1 ? aw : 0);
    endfunction

    // Payload width left after clipping against the output width.
    function automatic int clip_w(int pw, int used, int wout);
        if (used >= wout)
            return 0;
        if (used + pw > wout)
            return wout - used;
        return pw;
    endfunction

    // Output bits already consumed by flits 0..k-1.
    function automatic int used_before(int fw, int aw, int vcw,
                                       int wout, int k, bit head);
        int u;
        u = 0;
        for (int i = 0; i < k; i++)
            u += clip_w(payload_w(fw, aw, vcw, head && (i == 0)),
                        u, wout);
        return u;
    endfunction

endpackage

// File: rtl/pkt_skid_buffer.sv
// pkt_skid_buffer: 2-entry skid buffer, registered push_ready = not full.
// Ports: clk, rst_n, push_* (upstream), pop_* (downstream).
module pkt_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] push_data,
    input  logic             push_valid,
    output logic             push_ready,
    output logic [WIDTH-1:0] pop_data,
    output logic             pop_valid,
    input  logic             pop_ready
);

    logic [1:0]       count;
    logic [1:0]       count_nx;
    logic [WIDTH-1:0] ent0;
    logic [WIDTH-1:0] ent1;
    logic             ready_q;
    logic             push;
    logic             pop;

    assign push       = push_valid & ready_q;
    assign pop        = pop_valid & pop_ready;
    assign pop_valid  = (count != 2'd0);
    assign pop_data   = ent0;
    assign push_ready = ready_q;

    always_comb begin
        count_nx = count + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= 2'd0;
            ent0    <= '0;
            ent1    <= '0;
            ready_q <= 1'b0;
        end else begin
            count   <= count_nx;
            ready_q <= (count_nx != 2'd2);
            // ent0 is always the oldest word; push on a full buffer
            // cannot happen since ready is low then.
            if (pop) begin
                if (count == 2'd2)
                    ent0 <= ent1;
                else if (push)
                    ent0 <= push_data;
            end else if (push) begin
                if (count == 2'd0)
                    ent0 <= push_data;
                else
                    ent1 <= push_data;
            end
        end
    end

endmodule

// File: rtl/depacketizer_v2.sv
// depacketizer_v2: splits a 4-flit NoC word into header fields and a
// packed payload, through a 2-entry skid buffer (latency 1).
// Ports: i_data_in/i_valid_in/i_ready_out in; o_data_out, o_dest_out,
// o_vc_out, o_head_out, o_tail_out, o_valid_out/o_ready_in out;
// o_err_out sticky format error (only with DEPACKETIZER_ERR_CHECK_EN).
module depacketizer_v2
    import noc_pkt_pkg::*;
#(
    parameter int ADDRESS_WIDTH    = 4,
    parameter int VC_ADDRESS_WIDTH = 1,
    parameter int WIDTH_IN         = 532,
    parameter int WIDTH_OUT        = 512
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [WIDTH_IN-1:0]         i_data_in,
    input  logic                        i_valid_in,
    output logic                        i_ready_out,
    output logic [WIDTH_OUT-1:0]        o_data_out,
    output logic [ADDRESS_WIDTH-1:0]    o_dest_out,
    output logic [VC_ADDRESS_WIDTH-1:0] o_vc_out,
    output logic                        o_head_out,
    output logic [2:0]                  o_tail_out,
    output logic                        o_valid_out,
    input  logic                        o_ready_in,
    output logic                        o_err_out
);

    localparam int FW    = WIDTH_IN / 4;
    localparam int AW    = ADDRESS_WIDTH;
    localparam int VCW   = VC_ADDRESS_WIDTH;
    localparam int BUF_W = WIDTH_OUT + AW + VCW + 4;

    depkt_state_e state, state_nx;

    logic [3:0]           f_valid;
    logic [3:0]           f_head;
    logic [3:0]           f_tail;
    logic [VCW-1:0]       f_vc [4];
    logic [WIDTH_OUT-1:0] part_h [4];
    logic [WIDTH_OUT-1:0] part_b [4];

    logic                 accept;
    logic                 head_word;
    logic                 tail_any;
    logic [1:0]           tail_idx;
    logic [WIDTH_OUT-1:0] data;
    logic [AW-1:0]        dest;
    logic [BUF_W-1:0]     buf_d;
    logic [BUF_W-1:0]     buf_q;

    // Each flit yields its clipped payload already shifted into place,
    // once laid out as a head word and once as a body word.
    for (genvar k = 0; k < 4; k++) begin : g_flit
        localparam int TOP = WIDTH_IN - 1 - k * FW;
        localparam int H_U = used_before(FW, AW, VCW, WIDTH_OUT, k, 1'b1);
        localparam int H_W = clip_w(payload_w(FW, AW, VCW, k == 0),
                                    H_U, WIDTH_OUT);
        localparam int H_O = HDR_VC + VCW + ((k == 0) ? AW : 0);
        localparam int B_U = used_before(FW, AW, VCW, WIDTH_OUT, k, 1'b0);
        localparam int B_W = clip_w(payload_w(FW, AW, VCW, 1'b0),
                                    B_U, WIDTH_OUT);
        localparam int B_O = HDR_VC + VCW;

        assign f_valid[k] = i_data_in[TOP-HDR_VALID];
        assign f_head[k]  = i_data_in[TOP-HDR_HEAD];
        assign f_tail[k]  = i_data_in[TOP-HDR_TAIL];
        assign f_vc[k]    = i_data_in[TOP-HDR_VC -: VCW];

        if (H_W > 0) begin : g_h
            assign part_h[k] = WIDTH_OUT'(i_data_in[TOP-H_O -: H_W])
                               << (WIDTH_OUT - H_U - H_W);
        end else begin : g_hz
            assign part_h[k] = '0;
        end

        if (B_W > 0) begin : g_b
            assign part_b[k] = WIDTH_OUT'(i_data_in[TOP-B_O -: B_W])
                               << (WIDTH_OUT - B_U - B_W);
        end else begin : g_bz
            assign part_b[k] = '0;
        end
    end

    // The flit head bit is always 1 in flit 1, so head-word identity
    // comes from the FSM; the bits only feed the format check.
    logic unused_head;
    assign unused_head = ^f_head;

    assign accept    = i_valid_in & i_ready_out;
    assign head_word = (state == EXPECT_HEAD);

    // Descending scan so the lowest tailed flit wins.
    always_comb begin
        tail_any = 1'b0;
        tail_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (f_valid[i] && f_tail[i]) begin
                tail_any = 1'b1;
                tail_idx = 2'(i);
            end
        end
    end

    always_comb begin
        data = '0;
        for (int i = 0; i < 4; i++)
            data |= head_word ? part_h[i] : part_b[i];
    end

    assign dest  = head_word ?
                   i_data_in[WIDTH_IN-1-HDR_VC-VCW -: AW] : '0;
    assign buf_d = {head_word, tail_any, tail_idx, f_vc[0], dest, data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= EXPECT_HEAD;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (accept)
            state_nx = tail_any ? EXPECT_HEAD : IN_BODY;
    end

    pkt_skid_buffer #(
        .WIDTH (BUF_W)
    ) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_data  (buf_d),
        .push_valid (i_valid_in),
        .push_ready (i_ready_out),
        .pop_data   (buf_q),
        .pop_valid  (o_valid_out),
        .pop_ready  (o_ready_in)
    );

    assign {o_head_out, o_tail_out, o_vc_out, o_dest_out, o_data_out} = buf_q;

`ifdef DEPACKETIZER_ERR_CHECK_EN
    logic vc_bad;
    logic err_q;

    always_comb begin
        vc_bad = 1'b0;
        for (int i = 1; i < 4; i++)
            if (f_valid[i] && (f_vc[i] != f_vc[0]))
                vc_bad = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_q <= 1'b0;
        else if (accept && (!f_valid[0] || !f_head[0] || vc_bad))
            err_q <= 1'b1;
    end

    assign o_err_out = err_q;
`else
    assign o_err_out = 1'b0;
`endif

endmodule

// File: tb/tb_depacketizer_v2.sv
// tb_depacketizer_v2: table vectors, hand sequences and random traffic
// against a bit-stream reference model of the depacketizer.
module tb_depacketizer_v2;

    localparam int AW   = 4;
    localparam int VCW  = 1;
    localparam int WIN  = 532;
    localparam int WOUT = 512;
    localparam int FW   = WIN / 4;

`ifdef DEPACKETIZER_ERR_CHECK_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [WIN-1:0]  i_data_in = '0;
    logic            i_valid_in = 1'b0;
    logic            i_ready_out;
    logic [WOUT-1:0] o_data_out;
    logic [AW-1:0]   o_dest_out;
    logic [VCW-1:0]  o_vc_out;
    logic            o_head_out;
    logic [2:0]      o_tail_out;
    logic            o_valid_out;
    logic            o_ready_in = 1'b0;
    logic            o_err_out;

    depacketizer_v2 #(
        .ADDRESS_WIDTH    (AW),
        .VC_ADDRESS_WIDTH (VCW),
        .WIDTH_IN         (WIN),
        .WIDTH_OUT        (WOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_data_in   (i_data_in),
        .i_valid_in  (i_valid_in),
        .i_ready_out (i_ready_out),
        .o_data_out  (o_data_out),
        .o_dest_out  (o_dest_out),
        .o_vc_out    (o_vc_out),
        .o_head_out  (o_head_out),
        .o_tail_out  (o_tail_out),
        .o_valid_out (o_valid_out),
        .o_ready_in  (o_ready_in),
        .o_err_out   (o_err_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            head;
        logic [2:0]      tail;
        logic [AW-1:0]   dest;
        logic [VCW-1:0]  vc;
        logic [WOUT-1:0] data;
    } exp_t;

    typedef struct {
        logic [3:0]    vm;
        logic [3:0]    tm;
        logic [3:0]    vcm;
        logic [AW-1:0] dest;
        bit            pat;
        logic          e_head;
        logic [2:0]    e_tail;
        logic [AW-1:0] e_dest;
        logic [VCW-1:0] e_vc;
    } vec_t;

    exp_t sb[$];
    exp_t me;
    bit   in_pkt;
    bit   err_exp;
    bit   acc_last;
    bit   mon_en;
    int   acc_total;
    int   vec_cnt;
    int   bad_cnt;
    vec_t tbl [9];

    task automatic chk(input string nm, input logic [WOUT-1:0] act,
                       input logic [WOUT-1:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference: walk the flits as a bit stream, dropping header
    // fields and keeping payload bits until the output is full.
    function automatic exp_t model(input logic [WIN-1:0] w,
                                   input bit head);
        exp_t e;
        bit   q[$];
        int   top;
        int   skip;
        e.head = head;
        e.tail = 3'b000;
        e.dest = head ? w[WIN-1-3-VCW -: AW] : '0;
        e.vc   = w[WIN-4 -: VCW];
        for (int k = 0; k < 4; k++) begin
            top = WIN - 1 - k * FW;
            if (w[top] && w[top-2] && !e.tail[2])
                e.tail = {1'b1, 2'(k)};
            skip = 3 + VCW + ((head && k == 0) ? AW : 0);
            for (int j = 0; j < FW - skip; j++)
                if (q.size() < WOUT)
                    q.push_back(w[top-skip-j]);
        end
        e.data = '0;
        for (int i = 0; i < q.size(); i++)
            e.data[WOUT-1-i] = q[i];
        return e;
    endfunction

    function automatic bit bad_word(input logic [WIN-1:0] w);
        int top;
        if (!w[WIN-1] || !w[WIN-2])
            return 1'b1;
        for (int k = 1; k < 4; k++) begin
            top = WIN - 1 - k * FW;
            if (w[top] && (w[top-3] != w[WIN-4]))
                return 1'b1;
        end
        return 1'b0;
    endfunction

    // Masks use bit 3 for flit 1.
    function automatic logic [WIN-1:0] mk(input logic [3:0] vm,
        input logic [3:0] tm, input logic [3:0] vcm,
        input logic [AW-1:0] dest, input bit pat);
        logic [WIN-1:0] w;
        logic [7:0]     a5;
        int             top;
        a5 = 8'hA5;
        for (int i = 0; i < WIN; i++)
            w[i] = pat ? a5[i%8] : 1'($urandom);
        for (int k = 0; k < 4; k++) begin
            top = WIN - 1 - k * FW;
            w[top]   = vm[3-k];
            w[top-1] = (k == 0);
            w[top-2] = tm[3-k];
            w[top-3] = vcm[3-k];
        end
        w[WIN-1-3-VCW -: AW] = dest;
        return w;
    endfunction

    function automatic logic [WIN-1:0] rand_word();
        logic [3:0] vm;
        logic [3:0] tm;
        logic [3:0] vcm;
        int         idx;
        vm  = {1'b1, 3'($urandom)};
        tm  = ($urandom % 3 == 0) ? (4'b1000 >> ($urandom % 4)) : 4'b0;
        vcm = {4{1'($urandom)}};
        if ($urandom % 16 == 0) begin
            idx = $urandom % 4;
            vcm[idx] = ~vcm[idx];
        end
        return mk(vm, tm, vcm, AW'($urandom), 1'b0);
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            acc_last = 1'b0;
            chk("err", o_err_out, err_exp);
            chk("in_ready", i_ready_out, sb.size() < 2);
            chk("out_valid", o_valid_out, sb.size() > 0);
            if (o_valid_out && sb.size() > 0) begin
                me = sb[0];
                chk("head", o_head_out, me.head);
                chk("tail", o_tail_out, me.tail);
                chk("dest", o_dest_out, me.dest);
                chk("vc", o_vc_out, me.vc);
                chk("data", o_data_out, me.data);
                if (o_ready_in)
                    void'(sb.pop_front());
            end
            if (i_valid_in && i_ready_out) begin
                me = model(i_data_in, !in_pkt);
                sb.push_back(me);
                in_pkt = !me.tail[2];
                acc_last = 1'b1;
                acc_total++;
                if (ERR_ON && bad_word(i_data_in))
                    err_exp = 1'b1;
            end
        end
    end

    task automatic step(input bit v, input bit r);
        if (!i_valid_in || acc_last) begin
            i_valid_in = v;
            if (v)
                i_data_in = rand_word();
        end
        o_ready_in = r;
        @(posedge clk);
        #1;
    endtask

    task automatic step_w(input logic [WIN-1:0] w, input bit r);
        i_data_in  = w;
        i_valid_in = 1'b1;
        o_ready_in = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int a0;
        tbl[0] = '{4'hF, 4'h8, 4'h0, 4'h5, 1'b1, 1'b1, 3'b100, 4'h5, 1'b0};
        tbl[1] = '{4'hF, 4'h0, 4'hF, 4'hA, 1'b0, 1'b1, 3'b000, 4'hA, 1'b1};
        tbl[2] = '{4'hF, 4'h0, 4'hF, 4'h3, 1'b0, 1'b0, 3'b000, 4'h0, 1'b1};
        tbl[3] = '{4'hF, 4'h1, 4'hF, 4'h7, 1'b0, 1'b0, 3'b111, 4'h0, 1'b1};
        tbl[4] = '{4'hF, 4'h6, 4'h0, 4'h3, 1'b0, 1'b1, 3'b101, 4'h3, 1'b0};
        tbl[5] = '{4'hB, 4'h5, 4'h0, 4'h9, 1'b0, 1'b1, 3'b111, 4'h9, 1'b0};
        tbl[6] = '{4'hD, 4'h2, 4'h0, 4'hC, 1'b0, 1'b1, 3'b000, 4'hC, 1'b0};
        tbl[7] = '{4'hF, 4'h8, 4'h0, 4'h1, 1'b0, 1'b0, 3'b100, 4'h0, 1'b0};
        tbl[8] = '{4'hF, 4'h2, 4'h0, 4'hF, 1'b0, 1'b1, 3'b110, 4'hF, 1'b0};

        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid", o_valid_out, 0);
        chk("rst_ready", i_ready_out, 0);
        chk("rst_data", o_data_out, 0);
        chk("rst_head", o_head_out, 0);
        chk("rst_tail", o_tail_out, 0);
        chk("rst_dest", o_dest_out, 0);
        chk("rst_vc", o_vc_out, 0);
        chk("rst_err", o_err_out, 0);
        #19 rst_n = 1'b1;
        #1;
        chk("ready_low_after_rst", i_ready_out, 0);
        @(posedge clk);
        #1;
        chk("ready_rise", i_ready_out, 1);
        mon_en = 1'b1;

        for (int i = 0; i < 9; i++) begin
            step_w(mk(tbl[i].vm, tbl[i].tm, tbl[i].vcm, tbl[i].dest,
                      tbl[i].pat), 1'b1);
            chk($sformatf("tbl%0d_valid", i), o_valid_out, 1);
            chk($sformatf("tbl%0d_head", i), o_head_out, tbl[i].e_head);
            chk($sformatf("tbl%0d_tail", i), o_tail_out, tbl[i].e_tail);
            chk($sformatf("tbl%0d_dest", i), o_dest_out, tbl[i].e_dest);
            chk($sformatf("tbl%0d_vc", i), o_vc_out, tbl[i].e_vc);
        end
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);

        a0 = acc_total;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1);
            chk("b2b_ready", i_ready_out, 1);
            chk("b2b_valid", o_valid_out, 1);
        end
        chk("b2b_count", acc_total - a0, 20);
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1);
        chk("b2b_drain", o_valid_out, 0);

        a0 = acc_total;
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b0);
        chk("bp_accepts", acc_total - a0, 2);
        chk("bp_ready", i_ready_out, 0);
        for (int i = 0; i < 6; i++)
            step(1'b0, 1'b1);
        chk("bp_drain", o_valid_out, 0);

        for (int i = 0; i < 400; i++)
            step($urandom % 4 != 0, $urandom % 4 != 0);
        for (int i = 0; i < 8; i++)
            step(1'b0, 1'b1);
        chk("rand_drain", o_valid_out, 0);

        step_w(mk(4'hF, 4'h0, 4'h0, 4'h2, 1'b0), 1'b1);
        step_w(mk(4'hF, 4'h0, 4'h0, 4'h4, 1'b0), 1'b1);
        chk("mid_body_head", o_head_out, 0);
        i_valid_in = 1'b0;
        #2 rst_n = 1'b0;
        mon_en = 1'b0;
        sb.delete();
        in_pkt = 1'b0;
        err_exp = 1'b0;
        #1;
        chk("mid_rst_valid", o_valid_out, 0);
        chk("mid_rst_ready", i_ready_out, 0);
        chk("mid_rst_data", o_data_out, 0);
        chk("mid_rst_tail", o_tail_out, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk("mid_ready_low", i_ready_out, 0);
        @(posedge clk);
        #1;
        chk("mid_ready_rise", i_ready_out, 1);
        mon_en = 1'b1;
        step_w(mk(4'hF, 4'h0, 4'h0, 4'h6, 1'b0), 1'b1);
        chk("post_rst_head", o_head_out, 1);
        chk("post_rst_dest", o_dest_out, 6);
        step(1'b0, 1'b1);

        step_w(mk(4'hF, 4'h8, 4'b0100, 4'h1, 1'b0), 1'b1);
        chk("err_set", o_err_out, ERR_ON);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1);
            chk("err_sticky", o_err_out, ERR_ON);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vec_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/depacketizer_v2.md
DEPACKETIZER_V2 -- requirements
Module: depacketizer_v2

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 4: destination field width in the head word.
REQ-002 SHALL have parameter VC_ADDRESS_WIDTH, default 1: VC field width per flit.
REQ-003 SHALL have parameter WIDTH_IN, default 532: NoC word width, four flits of FW = WIDTH_IN/4 bits each.
REQ-004 SHALL have parameter WIDTH_OUT, default 512: reassembled data width.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all logic on rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port i_data_in, input, WIDTH_IN bits: NoC word; flit 1 is the MSB quarter.
REQ-008 SHALL have port i_valid_in, input, 1 bit: word valid.
REQ-009 SHALL have port i_ready_out, output, 1 bit: block can accept a word.
REQ-010 SHALL have port o_data_out, output, WIDTH_OUT bits: reassembled payload.
REQ-011 SHALL have port o_dest_out, output, ADDRESS_WIDTH bits: dest field; 0 on non-head words.
REQ-012 SHALL have port o_vc_out, output, VC_ADDRESS_WIDTH bits: VC field of flit 1.
REQ-013 SHALL have port o_head_out, output, 1 bit: word was the packet head word.
REQ-014 SHALL have port o_tail_out, output, 3 bits: [2] = packet ends in this word; [1:0] = index of tail flit (0 = flit 1).
REQ-015 SHALL have port o_valid_out, output, 1 bit: output valid.
REQ-016 SHALL have port o_ready_in, input, 1 bit: downstream ready.
REQ-017 SHALL have port o_err_out, output, 1 bit: sticky format error.

Function
REQ-018 Flit field layout, MSB first: valid, head, tail, VC, then (flit 1 of head word only) dest, then payload, zero padding at the LSB end.
REQ-019 Payload widths: head word flit 1 = FW-3-ADDRESS_WIDTH-VC_ADDRESS_WIDTH; all other flits = FW-3-VC_ADDRESS_WIDTH; each clipped so the running total does not exceed WIDTH_OUT.
REQ-020 o_data_out SHALL be the concatenation of the clipped payloads, flit 1 at the MSBs.
REQ-021 Head-word identity is decided by state; the flit head bit SHALL NOT be used, because it is always 1 in flit 1.
REQ-022 FSM states: EXPECT_HEAD (reset state) and IN_BODY.
REQ-023 On an accepted word in EXPECT_HEAD: o_head_out = 1; next state stays EXPECT_HEAD if a tail is present, else goes to IN_BODY.
REQ-024 On an accepted word in IN_BODY: o_head_out = 0; next state goes to EXPECT_HEAD if a tail is present, else stays IN_BODY.
REQ-025 Tail present = any valid flit has its tail bit set; o_tail_out[1:0] = lowest index among those flits.
REQ-026 Input handshake: a word is accepted when i_valid_in and i_ready_out are both 1.
REQ-027 Output handshake: a word is consumed when o_valid_out and o_ready_in are both 1.
REQ-028 Latency SHALL be 1 cycle from acceptance to o_valid_out.
REQ-029 Buffering SHALL be a 2-entry skid buffer; i_ready_out SHALL be registered and equal to "not full".
REQ-030 Full throughput of one word per cycle SHALL hold while o_ready_in = 1.
REQ-031 Simultaneous accept and consume on a full buffer SHALL be impossible, since ready is low when full.
REQ-032 Simultaneous accept and consume on a 1-entry buffer SHALL leave occupancy at 1.
REQ-033 Output fields SHALL be held stable while o_valid_out = 1 and o_ready_in = 0.

Reset
REQ-034 On rst_n low, immediately: FSM = EXPECT_HEAD; buffer empty; o_valid_out, o_err_out, o_head_out, o_tail_out, o_data_out, o_dest_out and o_vc_out = 0; i_ready_out = 0.
REQ-035 i_ready_out SHALL rise 1 cycle after rst_n deasserts.
REQ-036 Reset mid-packet SHALL discard buffered words; the next accepted word is treated as a head word.

Configuration
REQ-037 With macro DEPACKETIZER_ERR_CHECK_EN defined, o_err_out SHALL be set on an accepted word whose flit 1 valid bit is 0, whose flit 1 head bit is 0, or whose valid flits carry differing VC fields.
REQ-038 o_err_out SHALL stay set until reset.
REQ-039 Data flow SHALL be unaffected by an error.
REQ-040 Without DEPACKETIZER_ERR_CHECK_EN, o_err_out SHALL be tied 0 and no check logic is built.

Structure
REQ-041 Package noc_pkt_pkg SHALL hold the flit field offsets and the payload-width/clip functions, shared with packetizer_v2.
REQ-042 Sub-module pkt_skid_buffer (parameterised width) SHALL implement the 2-entry buffer.

Verification
REQ-043 Single-word packet: head word, flit 1 tail, dest 0x5, payload 0xA5 pattern -> one cycle later o_head_out = 1, o_tail_out = 3'b100, o_dest_out = 0x5, data matches; FSM stays EXPECT_HEAD.
REQ-044 Three-word packet with tail in flit 4 of word 3 -> o_head_out = 1,0,0; o_tail_out[2] set only on word 3 with [1:0] = 3; a body word shows 129+129+129+125 payload bits.
REQ-045 Hold o_ready_in = 0 for 5 cycles while streaming -> i_ready_out drops after 2 words; no loss or duplication; fields stable.
REQ-046 Assert rst_n low after word 2 of 4 -> outputs clear immediately; the next word is reported with o_head_out = 1.
REQ-047 With DEPACKETIZER_ERR_CHECK_EN: word with flit 2 VC = 1 and flit 1 VC = 0 -> o_err_out = 1 next cycle and stays 1; without the macro, o_err_out stays 0.
REQ-048 Back-to-back words with o_ready_in = 1 -> one output per cycle, i_ready_out constantly 1.
